// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: WIDTH add/shift iterations per
// product, with valid/ready handshakes on the operand and product sides.
module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic [WIDTH-1:0]   mq_q,    mq_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] p_q,     p_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    // The adder carry-out lands in sum[WIDTH] and shifts into the acc MSB.
    assign addend = mq_q[0] ? mcand_q : '0;
    assign sum    = {1'b0, acc_q} + {1'b0, addend};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = sum[WIDTH:1];
                mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                if (cnt_q == '0) begin
                    p_d     = {sum, mq_q[WIDTH-1:1]};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the datapath
    // registers are small and are cleared on reset so no stale operand survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC);
    assign p         = p_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: the driver queues hand-computed products,
// a monitor pops and compares whenever a product handshake occurs.
module tb_shift_add_mult;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] p;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int last_acc = 0;
    logic [7:0] exp_q[$];

    shift_add_mult #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a product transfers on the edge following a negedge where valid&&ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_product", 32'(p), 32'hFFFF_FFFF);
            end else begin
                check("product", 32'(p), 32'(exp_q.pop_front()));
                pops++;
            end
        end
    end

    // Called just after a posedge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] ai, input logic [3:0] bi,
                         input logic [7:0] expv, input bit hold);
        int n = 0;
        in_valid = 1'b1;
        a = ai;
        b = bi;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(n), 32'd0);
        end else begin
            exp_q.push_back(expv);
            @(posedge clk);
            last_acc = cyc;
            #1;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!out_valid && lat < 50) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct { logic [3:0] a; logic [3:0] b; logic [7:0] p; } vec_t;

    initial begin
        int lat, bn, pops0, acc_prev;
        vec_t b2b[5];
        vec_t t3[3];

        // 1: reset state, zero operands
        #22;
        check("rst_p", 32'(p), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        issue(4'd0, 4'd0, 8'h00, 1'b0);
        wait_done(lat, bn);
        check("latency_zero_ops", 32'(lat), 32'd4);
        drain();

        // 2: max product, busy duration
        issue(4'd15, 4'd15, 8'hE1, 1'b0);
        wait_done(lat, bn);
        check("latency_max", 32'(lat), 32'd4);
        check("busy_cycles", 32'(bn), 32'd4);
        drain();

        // 3: assorted vectors
        t3[0] = '{4'd13, 4'd11, 8'h8F};
        t3[1] = '{4'd1,  4'd15, 8'h0F};
        t3[2] = '{4'd8,  4'd2,  8'h10};
        foreach (t3[i]) issue(t3[i].a, t3[i].b, t3[i].p, 1'b0);
        drain();

        // 4: downstream stall holds the product
        out_ready = 1'b0;
        issue(4'd7, 4'd9, 8'h3F, 1'b0);
        wait_done(lat, bn);
        in_valid = 1'b1;
        a = 4'd1;
        b = 4'd1;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || p !== 8'h3F || in_ready) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_p", 32'(p), 32'h3F);
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            @(posedge clk); #1;
        end
        check("stall_end_valid", 32'(out_valid), 32'd1);
        check("stall_end_p", 32'(p), 32'h3F);
        check("stall_end_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_stall_idle", 32'(in_ready), 32'd1);
        check("post_stall_valid", 32'(out_valid), 32'd0);
        drain();

        // 5: reset in the middle of CALC discards the operation
        issue(4'd15, 4'd15, 8'hE1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_p", 32'(p), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        issue(4'd3, 4'd5, 8'h0F, 1'b0);
        wait_done(lat, bn);
        check("latency_after_rst", 32'(lat), 32'd4);
        drain();

        // 6: back-to-back issue with in_valid held high
        b2b[0] = '{4'd2,  4'd3,  8'h06};
        b2b[1] = '{4'd15, 4'd1,  8'h0F};
        b2b[2] = '{4'd9,  4'd9,  8'h51};
        b2b[3] = '{4'd12, 4'd10, 8'h78};
        b2b[4] = '{4'd5,  4'd14, 8'h46};
        pops0 = pops;
        acc_prev = 0;
        foreach (b2b[i]) begin
            issue(b2b[i].a, b2b[i].b, b2b[i].p, 1'b1);
            if (i > 0) check("issue_interval", 32'(last_acc - acc_prev), 32'd6);
            acc_prev = last_acc;
        end
        in_valid = 1'b0;
        drain();
        check("b2b_product_count", 32'(pops - pops0), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
